// File: rtl/ped_crossing_ctrl.sv
// ped_crossing_ctrl: pedestrian-side responder for the car traffic-light sequencer.
//
// Debounces two active-low push-buttons and raises a crossing request toward the
// car sequencer. Once the car side reports red, it runs a timed pedestrian green
// phase followed by a clearance phase. It then hands control back with a one-cycle
// done pulse.
//
// Optional feature macro: PED_FLASH_EN. When defined, ped_green flashes during
// CLEAR (ped_red off). Otherwise CLEAR shows solid red.
module ped_crossing_ctrl #(
    parameter int TICK_DIV    = 16777216,  // clock cycles per phase tick, >= 2
    parameter int DB_CYCLES   = 500000,    // stable cycles before a button level is accepted, >= 1
    parameter int GREEN_TICKS = 6,         // ticks of pedestrian green, >= 1
    parameter int CLEAR_TICKS = 2          // ticks of clearance after green, >= 1
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic key0,
    input  logic key1,
    input  logic car_red,
    output logic req,
    output logic done,
    output logic ped_red,
    output logic ped_green,
    output logic led_wait
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DB_W   = (DB_CYCLES > 0) ? $clog2(DB_CYCLES + 1) : 1;
    localparam int PH_MAX = (GREEN_TICKS > CLEAR_TICKS) ? GREEN_TICKS : CLEAR_TICKS;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CAR,
        GREEN,
        CLEAR,
        RELEASE
    } state_t;

    state_t            state;
    logic              key0_s1, key0_s2, key1_s1, key1_s2;
    logic              pressed_raw;
    logic              db_level;
    logic [DB_W-1:0]   db_cnt;
    logic              press_evt;
    logic [TICK_W-1:0] prescale;
    logic [PH_W-1:0]   phase;
    logic              tick;
    logic              green_last;
    logic              clear_last;

    // Either button counts; both pressed together is still a single level.
    assign pressed_raw = ~key0_s2 | ~key1_s2;

    assign tick       = (prescale == TICK_W'(TICK_DIV - 1));
    assign green_last = (phase == PH_W'(GREEN_TICKS - 1));
    assign clear_last = (phase == PH_W'(CLEAR_TICKS - 1));

    // Synchronize the raw keys, debounce the combined level, and pulse on press.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of the others; blocking here would collapse the
    // synchronizer stages into one.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            key0_s1   <= 1'b1;
            key0_s2   <= 1'b1;
            key1_s1   <= 1'b1;
            key1_s2   <= 1'b1;
            db_level  <= 1'b0;
            db_cnt    <= '0;
            press_evt <= 1'b0;
        end else begin
            key0_s1   <= key0;
            key0_s2   <= key0_s1;
            key1_s1   <= key1;
            key1_s2   <= key1_s1;
            press_evt <= 1'b0;
            if (pressed_raw != db_level) begin
                if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
                    db_level  <= pressed_raw;
                    db_cnt    <= '0;
                    press_evt <= pressed_raw;  // only released->pressed pulses
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;  // any glitch back to the accepted level restarts the count
            end
        end
    end

    // Crossing FSM with phase timing; outputs are registered alongside the state.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            prescale  <= '0;
            phase     <= '0;
            req       <= 1'b0;
            done      <= 1'b0;
            ped_red   <= 1'b1;
            ped_green <= 1'b0;
            led_wait  <= 1'b0;
        end else begin
            done <= 1'b0;

            // Timers run only inside the timed phases; entries below restart them.
            if (state == GREEN || state == CLEAR) begin
                prescale <= tick ? '0 : prescale + TICK_W'(1);
                if (tick) begin
                    phase <= phase + PH_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (press_evt) begin
                        state    <= WAIT_CAR;
                        req      <= 1'b1;
                        led_wait <= 1'b1;
                    end
                end

                WAIT_CAR: begin
                    if (car_red) begin
                        state     <= GREEN;
                        prescale  <= '0;
                        phase     <= '0;
                        ped_red   <= 1'b0;
                        ped_green <= 1'b1;
                        led_wait  <= 1'b0;
                    end
                end

                GREEN: begin
                    // Losing car red is a safety abort: leave green immediately.
                    if (!car_red || (tick && green_last)) begin
                        state    <= CLEAR;
                        prescale <= '0;
                        phase    <= '0;
`ifdef PED_FLASH_EN
                        ped_red   <= 1'b0;
                        ped_green <= 1'b1;
`else
                        ped_red   <= 1'b1;
                        ped_green <= 1'b0;
`endif
                    end
                end

                CLEAR: begin
`ifdef PED_FLASH_EN
                    if (tick) begin
                        ped_green <= ~ped_green;
                    end
`endif
                    if (tick && clear_last) begin
                        state     <= RELEASE;
                        done      <= 1'b1;
                        req       <= 1'b0;
                        ped_red   <= 1'b1;
                        ped_green <= 1'b0;
                    end
                end

                RELEASE: begin
                    // Hold off re-arming until the car side has left red.
                    if (!car_red) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    req       <= 1'b0;
                    ped_red   <= 1'b1;
                    ped_green <= 1'b0;
                    led_wait  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// tb_ped_crossing_ctrl: directed bench for ped_crossing_ctrl with small timing
// parameters. Stimulus pushes the expected output vector and the cycle at which it
// must appear. A monitor pops an entry whenever the output vector changes.
// Output vector order: {req, done, ped_red, ped_green, led_wait}.
module tb_ped_crossing_ctrl;

    logic clk;
    logic reset;
    logic key0;
    logic key1;
    logic car_red;
    logic req;
    logic done;
    logic ped_red;
    logic ped_green;
    logic led_wait;

    typedef struct {
        int         cyc;   // -1: any cycle
        logic [4:0] vec;
    } exp_t;

    exp_t       sb_q[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_fail = 0;
    logic [4:0] prev_vec = 'x;

    ped_crossing_ctrl #(
        .TICK_DIV   (4),
        .DB_CYCLES  (3),
        .GREEN_TICKS(3),
        .CLEAR_TICKS(2)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .key0     (key0),
        .key1     (key1),
        .car_red  (car_red),
        .req      (req),
        .done     (done),
        .ped_red  (ped_red),
        .ped_green(ped_green),
        .led_wait (led_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_cmp++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d, t=%0t)", name, act, req_v, cyc, $time);
        end
    endtask

    task automatic push(input int c, input logic [4:0] v);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        sb_q.push_back(e);
    endtask

    // Monitor: sample away from the active edge; check lamps every cycle and
    // compare each output change against the next scoreboard entry.
    always @(negedge clk) begin
        logic [4:0] v;
        exp_t       e;
        v = {req, done, ped_red, ped_green, led_wait};
`ifdef PED_FLASH_EN
        check("lamp_not_both_on", 32'(ped_red & ped_green), 32'd0);
`else
        check("lamp_exclusive", 32'(ped_red ^ ped_green), 32'd1);
`endif
        if (v !== prev_vec) begin
            if (sb_q.size() == 0) begin
                check("unexpected_change", 32'(v), 32'(prev_vec));
            end else begin
                e = sb_q.pop_front();
                check("evt_value", 32'(v), 32'(e.vec));
                if (e.cyc >= 0) begin
                    check("evt_cycle", cyc, e.cyc);
                end
            end
            prev_vec = v;
        end
    end

    initial begin
        int t;
        reset   = 1'b1;
        key0    = 1'b1;
        key1    = 1'b1;
        car_red = 1'b0;
        push(-1, 5'b00100);  // reset state: red only
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Short glitch on key1: shorter than the debounce window, no request.
        key1 = 1'b0;
        repeat (2) @(negedge clk);
        key1 = 1'b1;
        repeat (10) @(negedge clk);

        // Held key0: 2 sync + 3 debounce + 1 FSM cycles until req/led_wait.
        t = cyc;
        push(t + 6, 5'b10101);
        key0 = 1'b0;
        repeat (10) @(negedge clk);
        key0 = 1'b1;
        repeat (8) @(negedge clk);

        // Full crossing: green 12 cycles, clear 8 cycles, done pulse, release.
        t = cyc;
        car_red = 1'b1;
        push(t + 1, 5'b10010);
`ifdef PED_FLASH_EN
        push(t + 17, 5'b10000);
`else
        push(t + 13, 5'b10100);
`endif
        push(t + 21, 5'b01100);
        push(t + 22, 5'b00100);
        repeat (2) @(negedge clk);
        key0 = 1'b0;             // press during GREEN: ignored
        repeat (6) @(negedge clk);
        key0 = 1'b1;
        repeat (15) @(negedge clk);
        key0 = 1'b0;             // press during RELEASE: ignored
        repeat (8) @(negedge clk);
        key0 = 1'b1;
        repeat (9) @(negedge clk);
        car_red = 1'b0;          // RELEASE -> IDLE, outputs unchanged
        repeat (4) @(negedge clk);

        // Safety abort: car_red drops after 5 cycles of green.
        t = cyc;
        key0 = 1'b0;
        push(t + 6, 5'b10101);
        repeat (8) @(negedge clk);
        key0 = 1'b1;
        repeat (2) @(negedge clk);
        t = cyc;
        car_red = 1'b1;
        push(t + 1, 5'b10010);
`ifdef PED_FLASH_EN
        push(t + 10, 5'b10000);
`else
        push(t + 6, 5'b10100);
`endif
        push(t + 14, 5'b01100);
        push(t + 15, 5'b00100);
        repeat (5) @(negedge clk);
        car_red = 1'b0;
        repeat (14) @(negedge clk);

        // Press with car_red already high: WAIT_CAR then GREEN one cycle later,
        // then an asynchronous reset in the middle of green.
        t = cyc;
        key0    = 1'b0;
        car_red = 1'b1;
        push(t + 6, 5'b10101);
        push(t + 7, 5'b10010);
        repeat (10) @(negedge clk);
        push(cyc + 1, 5'b00100);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", 32'({req, done, ped_red, ped_green, led_wait}), 32'(5'b00100));
        key0    = 1'b1;
        car_red = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
